mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX/MEM register; feeds the MEM/WB register.
- Non-memory instructions pass through combinationally.
- Loads and stores run a word-wide bus transaction under a small FSM, with a stall request to the hazard unit until the access completes.
- Loads: byte/half extraction with sign or zero extension.

Parameters:
- ADDR_W, 32, bus/byte address width.
- DATA_W, 32, data width; fixed at 32, 4 byte lanes.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_wd_i  in  5  destination register from EX/MEM.
- mem_wreg_i  in  1  write-enable from EX/MEM.
- mem_wdata_i  in  32  ALU result from EX/MEM.
- mem_op_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
- mem_addr_i  in  32  byte address.
- mem_sdata_i  in  32  store data (low bits significant for SB/SH).
- bus_req_o  out  1  transaction request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word address {mem_addr_i[31:2],2'b00}.
- bus_be_o  out  4  byte enables, lane 0 = bits 7:0.
- bus_wdata_o  out  32  store data replicated across lanes.
- bus_rdata_i  in  32  read data, valid with ack.
- bus_ack_i  in  1  one-cycle completion pulse.
- stall_req_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- wb_wd_o  out  5  to MEM/WB.
- wb_wreg_o  out  1  to MEM/WB.
- wb_wdata_o  out  32  to MEM/WB.

Behaviour:
- Reset (rst_i=0, async):
  - State IDLE, rdata latch 0.
  - All outputs 0 while asserted.
  - Mid-transaction reset drops bus_req_o immediately; any later ack is ignored.
- FSM states IDLE, ACCESS, DONE.
  - IDLE, non-memory op: wb_* = mem_* inputs, stall_req_o=0, bus_req_o=0; stay IDLE.
  - IDLE, memory op: stall_req_o=1, wb_wreg_o=0 (bubble); next ACCESS.
  - ACCESS: bus_req_o=1, stall_req_o=1, wb_wreg_o=0.
    - bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o held stable from current inputs.
    - On bus_ack_i=1: latch bus_rdata_i, next DONE. Otherwise stay; there is no timeout.
  - DONE: bus_req_o=0, stall_req_o=0.
    - Load: wb_wreg_o=mem_wreg_i, wb_wd_o=mem_wd_i, wb_wdata_o=formatted latched data.
    - Store: wb_wreg_o=0.
    - Next IDLE; upstream register advances at this edge.
- Latency: memory op occupies 2+N cycles, N = cycles from request to ack (N>=1). Minimum 3.
- Byte enables, a = addr[1:0]:
  - SB: 1<<a.
  - SH: a[1]?4'b1100:4'b0011.
  - SW: 4'b1111.
  - Loads: 4'b1111.
- Store data:
  - SB: {4{sdata[7:0]}}.
  - SH: {2{sdata[15:0]}}.
  - SW: sdata.
- Load formatting, lane chosen by a:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW whole word.
- Misalignment is ignored: low address bits select lanes as above, and LW/SW ignore addr[1:0].
- When stall_req_o is low, bus_* are 0 except bus_addr_o, which is don't-care.
- Back-to-back memory ops: DONE → IDLE → ACCESS, with no lost or duplicated request.
- Ack outside ACCESS is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Extra output port misalign_o (1 bit).
  - For LH/LHU/SH with a[0]=1, or LW/SW with a!=0: no bus request. FSM goes IDLE → DONE directly, with stall_req_o=1 for one cycle.
  - In DONE: misalign_o=1, wb_wreg_o=0.
  - misalign_o is 0 otherwise and on reset.
- Not defined: no port; behaviour as above with misalignment ignored.

Test Plan:
- Reset mid-ACCESS: assert rst_i=0 with bus_req_o=1 → bus_req_o, stall_req_o and wb_* go 0 the same cycle. After release, state is IDLE, and an ack arriving next cycle is ignored.
- Pass-through: op=0, wd=5'd3, wreg=1, wdata=32'h1234_5678 → wb_* equal inputs the same cycle, stall_req_o=0, bus_req_o=0.
- LB with sign extension: addr=32'h0000_1003, rdata=32'h80FF_0000, ack on the 1st ACCESS cycle → bus_addr_o=32'h1000, stall high 2 cycles, DONE wb_wdata_o=32'hFFFF_FF80.
- LHU: addr=32'h0000_1002, rdata=32'h8001_0000, ack delayed 3 cycles → stall high 4 cycles, wb_wdata_o=32'h0000_8001.
- SB: addr=32'h2001, sdata=32'h0000_00AB → bus_be_o=4'b0010, bus_wdata_o=32'hABAB_ABAB, bus_we_o=1, wb_wreg_o=0 throughout.
- Back-to-back SW then LW: each issues exactly one bus_req burst, with one IDLE cycle between them.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline MEM stage: pass-through for ALU ops, FSM-driven word bus access for loads/stores.
// Optional alignment trap enabled by defining MEM_ALIGN_CHECK_EN (adds misalign_o).
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        mem_wd_i,
  input  logic              mem_wreg_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_sdata_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stall_req_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q;

  logic              is_load, is_store, is_mem, misal;
  logic [1:0]        a;
  logic [3:0]        be;
  logic [DATA_W-1:0] st_data, ld_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign a        = mem_addr_i[1:0];
  assign is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
  assign is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
  assign is_mem   = is_load || is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) && a[0]) ||
                 (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (a != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    be      = 4'b1111;
    st_data = mem_sdata_i;
    case (mem_op_i)
      OP_SB: begin
        be      = 4'b0001 << a;
        st_data = {4{mem_sdata_i[7:0]}};
      end
      OP_SH: begin
        be      = a[1] ? 4'b1100 : 4'b0011;
        st_data = {2{mem_sdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Low address bits pick the lane even when misaligned.
  assign byte_v = rdata_q[{a, 3'b000} +: 8];
  assign half_v = a[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    case (mem_op_i)
      OP_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  ld_data = {24'b0, byte_v};
      OP_LH:   ld_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  ld_data = {16'b0, half_v};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    stall_req_o = 1'b0;
    wb_wd_o     = '0;
    wb_wreg_o   = 1'b0;
    wb_wdata_o  = '0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_o  = 1'b0;
`endif
    // Outputs are forced low combinationally while reset is held.
    if (rst_i) begin
      case (state_q)
        IDLE: begin
          if (!is_mem) begin
            wb_wd_o    = mem_wd_i;
            wb_wreg_o  = mem_wreg_i;
            wb_wdata_o = mem_wdata_i;
          end else begin
            stall_req_o = 1'b1;
            state_d     = misal ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          bus_req_o   = 1'b1;
          stall_req_o = 1'b1;
          bus_we_o    = is_store;
          bus_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          bus_be_o    = be;
          bus_wdata_o = is_store ? st_data : '0;
          if (bus_ack_i) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          wb_wd_o = mem_wd_i;
          if (is_load && !misal) begin
            wb_wreg_o  = mem_wreg_i;
            wb_wdata_o = ld_data;
          end
`ifdef MEM_ALIGN_CHECK_EN
          misalign_o = misal;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ACCESS && bus_ack_i) rdata_q <= bus_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-timeline reference model checked every cycle,
// directed literal checks from the test plan, then randomized operations.
module tb_mem_stage;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  mem_wd_i = '0;
  logic        mem_wreg_i = 1'b0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_sdata_i = '0;
  logic        bus_req_o, bus_we_o, stall_req_o, wb_wreg_o;
  logic [31:0] bus_addr_o, bus_wdata_o, wb_wdata_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  wb_wd_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_req_o(stall_req_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
    .wb_wdata_o(wb_wdata_o)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference rules
  function automatic bit is_ld(input logic [3:0] op); return op >= 1 && op <= 5; endfunction
  function automatic bit is_st(input logic [3:0] op); return op >= 6 && op <= 8; endfunction

  function automatic bit misal_f(input logic [3:0] op, input logic [1:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return ((op == 3 || op == 4 || op == 7) && a[0]) || ((op == 5 || op == 8) && a != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] fmt_f(input logic [3:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] s;
    case (op)
      1: begin s = rd >> (8 * a); return {{24{s[7]}}, s[7:0]}; end
      2: begin s = rd >> (8 * a); return {24'b0, s[7:0]}; end
      3: begin s = rd >> (16 * a[1]); return {{16{s[15]}}, s[15:0]}; end
      4: begin s = rd >> (16 * a[1]); return {16'b0, s[15:0]}; end
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [3:0] op, input logic [1:0] a);
    logic [3:0] one;
    one = 4'b0001;
    if (op == 6) return one << a;
    if (op == 7) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] sd_f(input logic [3:0] op, input logic [31:0] sd);
    logic [31:0] r;
    r = sd;
    if (op == 6) for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[7:0];
    if (op == 7) r = {sd[15:0], sd[15:0]};
    return r;
  endfunction

  // Model state: position in the current operation's timeline.
  bit          model_en = 0;
  int          m_c = 0;
  int          m_n = 1;
  logic [31:0] m_rd = '0;

  // Observations for literal checks
  int          obs_stall, obs_bursts, obs_gap, obs_last_gap;
  bit          obs_prev_req, obs_wreg_any, obs_we;
  logic [31:0] obs_addr, obs_wdata, obs_done_wdata;
  logic [3:0]  obs_be;

  task automatic clr_obs();
    obs_stall = 0; obs_bursts = 0; obs_gap = 0; obs_last_gap = -1;
    obs_prev_req = 0; obs_wreg_any = 0; obs_we = 0;
    obs_addr = '0; obs_wdata = '0; obs_done_wdata = '0; obs_be = '0;
  endtask

  always @(negedge clk_i) if (model_en) begin
    logic [1:0] a;
    bit ld, st, mis, req;
    int ne;
    a   = mem_addr_i[1:0];
    ld  = is_ld(mem_op_i);
    st  = is_st(mem_op_i);
    mis = (ld || st) && misal_f(mem_op_i, a);
    ne  = mis ? 0 : m_n;
    req = 0;
    if (!(ld || st)) begin
      chk("pass_wd", wb_wd_o, mem_wd_i);
      chk("pass_wreg", wb_wreg_o, mem_wreg_i);
      chk("pass_wdata", wb_wdata_o, mem_wdata_i);
      chk("pass_stall", stall_req_o, 0);
      chk("pass_req", bus_req_o, 0);
      chk("pass_bus", {bus_we_o, bus_be_o, bus_wdata_o[26:0]}, 0);
    end else if (m_c <= ne) begin
      req = (m_c >= 1);
      chk("acc_stall", stall_req_o, 1);
      chk("acc_wreg", wb_wreg_o, 0);
      chk("acc_req", bus_req_o, req);
      if (req) begin
        chk("acc_we", bus_we_o, st);
        chk("acc_addr", bus_addr_o, {mem_addr_i[31:2], 2'b00});
        chk("acc_be", bus_be_o, be_f(mem_op_i, a));
        if (st) chk("acc_wdata", bus_wdata_o, sd_f(mem_op_i, mem_sdata_i));
      end
    end else begin
      chk("done_stall", stall_req_o, 0);
      chk("done_req", bus_req_o, 0);
      chk("done_bus", {bus_we_o, bus_be_o, bus_wdata_o[26:0]}, 0);
      if (ld && !mis) begin
        chk("done_wreg", wb_wreg_o, mem_wreg_i);
        chk("done_wd", wb_wd_o, mem_wd_i);
        chk("done_wdata", wb_wdata_o, fmt_f(mem_op_i, a, m_rd));
      end else chk("done_wreg0", wb_wreg_o, 0);
      obs_done_wdata = wb_wdata_o;
    end
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign", misalign_o, (ld || st) && m_c == ne + 1 && mis);
`endif
    if (stall_req_o) obs_stall++;
    if (wb_wreg_o) obs_wreg_any = 1;
    if (bus_req_o) begin
      if (!obs_prev_req) begin obs_bursts++; obs_last_gap = obs_gap; end
      obs_gap = 0;
      obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata = bus_wdata_o; obs_we = bus_we_o;
    end else obs_gap++;
    obs_prev_req = bus_req_o;
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [31:0] rd, input int n, input bit noise);
    bit mem, mis;
    int cycles;
    mem = is_ld(op) || is_st(op);
    mis = mem && misal_f(op, addr[1:0]);
    cycles = !mem ? 1 : (mis ? 2 : n + 2);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sd;
    mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = wdata;
    m_rd = rd; m_n = n;
    for (int c = 0; c < cycles; c++) begin
      m_c = c;
      if (mem && !mis && c >= 1 && c <= n) bus_ack_i = (c == n);
      else bus_ack_i = noise && ($urandom_range(0, 2) == 0);
      bus_rdata_i = (mem && !mis && c == n) ? rd : $urandom();
      @(posedge clk_i); #1;
    end
    bus_ack_i = 1'b0;
  endtask

  initial begin
    clr_obs();
    #1;
    chk("rst_req", bus_req_o, 0);
    chk("rst_stall", stall_req_o, 0);
    chk("rst_wb", {wb_wd_o, wb_wreg_o, wb_wdata_o[25:0]}, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_en = 1;

    // Pass-through literal
    mem_op_i = 0; mem_wd_i = 5'd3; mem_wreg_i = 1; mem_wdata_i = 32'h1234_5678;
    #1;
    chk("lit_pass_wdata", wb_wdata_o, 32'h1234_5678);
    chk("lit_pass_wd", wb_wd_o, 5'd3);
    chk("lit_pass_wreg", wb_wreg_o, 1);
    chk("lit_pass_stall", stall_req_o, 0);
    chk("lit_pass_req", bus_req_o, 0);
    @(posedge clk_i); #1;

    clr_obs();
    do_op(1, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h0, 32'h80FF_0000, 1, 0);
    chk("lit_lb_stall", obs_stall, 2);
    chk("lit_lb_addr", obs_addr, 32'h0000_1000);
    chk("lit_lb_data", obs_done_wdata, 32'hFFFF_FF80);

    clr_obs();
    do_op(4, 32'h0000_1002, 32'h0, 5'd9, 1, 32'h0, 32'h8001_0000, 3, 0);
    chk("lit_lhu_stall", obs_stall, 4);
    chk("lit_lhu_data", obs_done_wdata, 32'h0000_8001);

    clr_obs();
    do_op(6, 32'h0000_2001, 32'h0000_00AB, 5'd4, 1, 32'h0, 32'h0, 2, 0);
    chk("lit_sb_be", obs_be, 4'b0010);
    chk("lit_sb_wdata", obs_wdata, 32'hABAB_ABAB);
    chk("lit_sb_we", obs_we, 1);
    chk("lit_sb_wreg", obs_wreg_any, 0);

    clr_obs();
    do_op(8, 32'h0000_3000, 32'hDEAD_BEEF, 5'd1, 1, 32'h0, 32'h0, 2, 0);
    do_op(5, 32'h0000_3004, 32'h0, 5'd2, 1, 32'h0, 32'hCAFE_F00D, 1, 0);
    chk("lit_b2b_bursts", obs_bursts, 2);
    chk("lit_b2b_gap", obs_last_gap, 2);

    // Reset during ACCESS
    model_en = 0;
    mem_op_i = 1; mem_addr_i = 32'h0000_1003; mem_wd_i = 5'd7; mem_wreg_i = 1;
    bus_ack_i = 0;
    @(posedge clk_i); #1;
    chk("rst_mid_req_before", bus_req_o, 1);
    rst_i = 1'b0;
    #1;
    chk("rst_mid_req", bus_req_o, 0);
    chk("rst_mid_stall", stall_req_o, 0);
    chk("rst_mid_wb", {wb_wd_o, wb_wreg_o, wb_wdata_o[25:0]}, 0);
    mem_op_i = 0; mem_wreg_i = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    bus_ack_i = 1; bus_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    chk("rst_ack_stall", stall_req_o, 0);
    chk("rst_ack_req", bus_req_o, 0);
    @(posedge clk_i); #1;
    bus_ack_i = 0;
    @(negedge clk_i);
    chk("rst_post_stall", stall_req_o, 0);
    chk("rst_post_req", bus_req_o, 0);
    @(posedge clk_i); #1;
    model_en = 1;

    // Randomized operations
    for (int i = 0; i < 400; i++) begin
      do_op(4'($urandom_range(0, 15)), $urandom(), $urandom(), 5'($urandom()), 1'($urandom()),
            $urandom(), $urandom(), $urandom_range(1, 4), 1);
    end

    model_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
